// File: rtl/tut_nios_nios2_qsys_0_oci_dct_ctrl.sv
// tut_nios_nios2_qsys_0_oci_dct_ctrl: packs trace items into words and streams them to the trace RAM writer
module tut_nios_nios2_qsys_0_oci_dct_ctrl #(
  parameter int ITEM_W = 2,
  parameter int ITEMS  = 15,
  parameter int ADDR_W = 7,
  parameter int WRAP   = 1
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           trc_on,
  input  logic                                           item_valid,
  input  logic [ITEM_W-1:0]                              item_data,
  output logic                                           item_ready,
  input  logic                                           flush_req,
  input  logic                                           trc_stop,
  output logic                                           tw_valid,
  output logic [$clog2(ITEMS+1)+ITEM_W*ITEMS-1:0]        tw_data,
  output logic [ADDR_W-1:0]                              tw_addr,
  input  logic                                           tw_ready,
  output logic [ITEM_W*ITEMS-1:0]                        dct_buffer,
  output logic [$clog2(ITEMS+1)-1:0]                     dct_count,
  output logic                                           trc_wrap,
  output logic                                           trc_full,
  output logic                                           test_ending,
  output logic                                           test_has_ended
);
  localparam int BW = ITEM_W * ITEMS;
  localparam int CW = $clog2(ITEMS + 1);
  typedef enum logic [1:0] {PACK, EMIT, DRAIN, DONE} state_t;
  state_t            state_q;
  logic              stop_q;
  logic              valid_q, wrap_q, full_q, ending_q, ended_q;
  logic [CW+BW-1:0]  data_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BW-1:0]     buf_q, buf_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              acc, last;
  assign item_ready     = (state_q == PACK) & trc_on & ~full_q;
  assign acc            = item_valid & item_ready;
  assign last           = &addr_q;
  // the incoming item lands in the slot indexed by the current count
  assign buf_d          = buf_q | (acc ? BW'(item_data) << (ITEM_W * int'(cnt_q)) : '0);
  assign cnt_d          = cnt_q + CW'(acc);
  assign tw_valid       = valid_q;
  assign tw_data        = data_q;
  assign tw_addr        = addr_q;
  assign dct_buffer     = buf_q;
  assign dct_count      = cnt_q;
  assign trc_wrap       = wrap_q;
  assign trc_full       = full_q;
  assign test_ending    = ending_q;
  assign test_has_ended = ended_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PACK;
      stop_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      addr_q   <= '0;
      buf_q    <= '0;
      cnt_q    <= '0;
      wrap_q   <= 1'b0;
      full_q   <= 1'b0;
      ending_q <= 1'b0;
      ended_q  <= 1'b0;
    end else begin
      case (state_q)
        PACK: begin
          buf_q <= buf_d;
          cnt_q <= cnt_d;
          if (trc_stop) begin
            state_q  <= DRAIN;
            ending_q <= 1'b1;
          end else if (cnt_d == CW'(ITEMS) || (flush_req && cnt_d != '0)) begin
            state_q <= EMIT;
            valid_q <= 1'b1;
            data_q  <= {cnt_d, buf_d};
          end
        end
        EMIT: begin
          if (trc_stop) begin
            stop_q   <= 1'b1;
            ending_q <= 1'b1;
          end
          if (tw_ready) begin
            valid_q <= 1'b0;
            buf_q   <= '0;
            cnt_q   <= '0;
            if (last && WRAP == 0) full_q <= 1'b1;
            else addr_q <= addr_q + 1'b1;
            if (last && WRAP != 0) wrap_q <= 1'b1;
            if ((last && WRAP == 0) || stop_q || trc_stop) begin
              state_q  <= DONE;
              ending_q <= 1'b0;
              ended_q  <= 1'b1;
            end else state_q <= PACK;
          end
        end
        DRAIN: begin
          if (cnt_q != '0) begin
            state_q <= EMIT;
            valid_q <= 1'b1;
            data_q  <= {cnt_q, buf_q};
            stop_q  <= 1'b1;
          end else begin
            state_q  <= DONE;
            ending_q <= 1'b0;
            ended_q  <= 1'b1;
          end
        end
        default: state_q <= DONE;
      endcase
    end
  end
endmodule

// File: doc/tut_nios_nios2_qsys_0_oci_dct_ctrl.md
Name: tut_nios_nios2_qsys_0_oci_dct_ctrl

Overview:
- Sequences the OCI data-capture trace (DCT) datapath.
- Packs 2-bit trace items into the 30-bit dct_buffer and tracks occupancy in dct_count.
- Emits completed or flushed words to the on-chip trace RAM writer through a valid/ready handshake, and manages the trace RAM write address with wrap or stop policy.
- Drives test_ending and test_has_ended for the end-of-trace drain sequence.

Parameters:
- ITEM_W, 2, width of one trace item (fixed; buffer width is ITEM_W*ITEMS).
- ITEMS, 15, item slots per trace word.
- ADDR_W, 7, trace RAM address width (128 entries).
- WRAP, 1, 1 = address wraps and sets trc_wrap; 0 = capture stops when the RAM is full.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- trc_on  in  1  capture enable.
- item_valid  in  1  trace item offered.
- item_data  in  2  trace item code.
- item_ready  out  1  item accepted this cycle when item_valid is also high.
- flush_req  in  1  single-cycle pulse: emit the partial word.
- trc_stop  in  1  single-cycle pulse: drain and end capture.
- tw_valid  out  1  trace word valid.
- tw_data  out  34  trace word {dct_count, dct_buffer}.
- tw_addr  out  7  RAM address for tw_data.
- tw_ready  in  1  RAM writer accepts the word.
- dct_buffer  out  30  current pack buffer; item k occupies bits [2k+1:2k].
- dct_count  out  4  items held (0..15).
- trc_wrap  out  1  sticky: address has wrapped.
- trc_full  out  1  sticky: RAM full (WRAP=0 only).
- test_ending  out  1  drain in progress.
- test_has_ended  out  1  capture finished.

Behaviour:
- Reset: state PACK. All outputs are 0: dct_buffer, dct_count, tw_valid, tw_data, tw_addr, trc_wrap, trc_full, test_ending, test_has_ended.
- States: PACK, EMIT, DRAIN, DONE.
- item_ready = (state==PACK) & trc_on & ~trc_full.
- PACK, accept rule: on an accepted item, the item is written to slot dct_count and dct_count increments. Registered outputs reflect the item next cycle.
- PACK, word complete: an accept that brings dct_count to 15 latches tw_data and moves to EMIT. tw_valid rises the cycle after the 15th accept.
- PACK, flush: flush_req with dct_count>0 latches a partial word and moves to EMIT. Unused slots are zero. flush_req with dct_count==0 is ignored.
- PACK, item and flush in the same cycle: the item is packed first, then the word (including that item) is emitted.
- PACK, trc_stop: go to DRAIN. trc_stop has priority over flush_req. An item accepted in the same cycle is packed before the drain.
- EMIT: tw_valid=1, with tw_data and tw_addr held stable until tw_ready.
  - On acceptance: dct_buffer and dct_count clear, tw_valid drops next cycle, and tw_addr increments modulo 2^ADDR_W.
  - Next state is PACK, or DONE if entered from DRAIN.
  - flush_req and trc_stop during EMIT: flush is ignored. trc_stop is remembered, and the state goes to DONE after the accept.
- Address wrap, WRAP=1: an accept at address 127 sets tw_addr to 0 and sets trc_wrap.
- Address full, WRAP=0: an accept at address 127 sets trc_full, holds tw_addr at 127, and moves to DONE.
- DRAIN: test_ending=1.
  - If dct_count>0, latch the partial word and go to EMIT, keeping test_ending=1 until the accept.
  - Otherwise go to DONE the next cycle.
- DONE: test_has_ended=1 and test_ending=0. item_ready=0. Stays until reset.
- trc_on low: items are not accepted; the partial word is retained. Flush and stop still operate.
- Reset mid-EMIT: the word is discarded and all state is cleared on the same edge.

Test Plan:
- Fill: 15 items (item k = k mod 4, k=0..14) with tw_ready=1 -> tw_data=34'h3_E4E4E4E4 (dct_count=15, buffer 30'h24E4E4E4) at tw_addr 0. tw_valid high for exactly one cycle, starting the cycle after the 15th accept. dct_count returns to 0.
- Backpressure: hold tw_ready=0 for 5 cycles during EMIT -> tw_valid, tw_data and tw_addr stay stable, item_ready=0. Word accepted on the first tw_ready cycle, then tw_addr=1.
- Flush: 3 items (1,2,3), then flush_req -> tw_data={4'd3, 30'h39}. flush_req with dct_count 0 -> no tw_valid.
- Simultaneous item and flush: item 2 in the same cycle as flush_req, with 1 item already held (item 1) -> tw_data={4'd2, 30'h9}.
- Wrap: WRAP=1, 129 full words -> trc_wrap set after the 128th accept, 129th word at tw_addr 0. WRAP=0 -> trc_full set after the 128th accept, state DONE, item_ready=0.
- Drain: 4 items, then trc_stop -> test_ending=1 until the partial word {4'd4,...} is accepted, then test_has_ended=1. trc_stop with an empty buffer -> test_has_ended one cycle later. Reset mid-EMIT -> all outputs 0 the next cycle.
